// File: rtl/act_seq_pkg.sv
// Shared types and sizing helpers for the activation LUT sequencer family.
// Defaults here describe the reference configuration; modules derive their own widths.
package act_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CALC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_NEURONS_DEF = 4;
    localparam int DATA_W_DEF    = 8;

    // A single-element sequencer still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W  = idx_width(N_NEURONS_DEF);
    localparam int DIFF_W = DATA_W_DEF + 1;

endpackage

// File: rtl/act_lut_interp.sv
// Piecewise-linear interpolation between two LUT entries: y = base + floor((next-base)*frac / 2^FRAC_W).
// Purely combinational so it can be shared by any layer's sequencer.
module act_lut_interp #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    input  logic [FRAC_W-1:0] frac,
    output logic [DATA_W-1:0] y
);

    localparam int D_W = DATA_W + 1;
    localparam int P_W = D_W + FRAC_W + 1;

    logic signed [D_W-1:0] diff_s;
    logic signed [P_W-1:0] prod_s;
    logic signed [P_W-1:0] shift_s;

    // Result always lies between base and next, so truncation never wraps.
    always_comb begin
        diff_s  = $signed({lut_next[DATA_W-1], lut_next}) - $signed({lut_base[DATA_W-1], lut_base});
        prod_s  = P_W'(diff_s) * P_W'($signed({1'b0, frac}));
        shift_s = prod_s >>> FRAC_W;
        y       = DATA_W'(P_W'($signed(lut_base)) + shift_s);
    end

endmodule

// File: rtl/act_lut_sequencer.sv
// Time-multiplexes one external activation LUT across an N-element input vector,
// fetching and interpolating one element every two cycles.
module act_lut_sequencer
    import act_seq_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IN_W      = 8,
    parameter int ADDR_W    = 4,
    parameter int FRAC_W    = 4,
    parameter int DATA_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_NEURONS*IN_W-1:0]   x_vec,
    output logic [ADDR_W-1:0]           lut_addr,
    input  logic [DATA_W-1:0]           lut_base,
    input  logic [DATA_W-1:0]           lut_next,
    output logic                        busy,
    output logic                        done,
    output logic [N_NEURONS*DATA_W-1:0] y_vec
);

    localparam int IDX_BITS = idx_width(N_NEURONS);
    localparam int LAST     = N_NEURONS - 1;

    state_t                      state_q, state_d;
    logic [IDX_BITS-1:0]         idx_q, idx_d;
    logic [IDX_BITS-1:0]         idx_nxt_s;
    logic [N_NEURONS*IN_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]           base_q, base_d;
    logic [DATA_W-1:0]           next_q, next_d;
    logic [FRAC_W-1:0]           frac_q, frac_d;
    logic [ADDR_W-1:0]           lut_addr_q, lut_addr_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [N_NEURONS*DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0]           interp_y_s;

    act_lut_interp #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_interp (
        .lut_base (base_q),
        .lut_next (next_q),
        .frac     (frac_q),
        .y        (interp_y_s)
    );

    assign idx_nxt_s = idx_q + IDX_BITS'(1);

    // lut_addr is registered, so it is loaded on the edge entering FETCH to be stable throughout FETCH.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        base_d     = base_q;
        next_d     = next_q;
        frac_d     = frac_q;
        lut_addr_d = lut_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        y_d        = y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    x_d        = x_vec;
                    idx_d      = {IDX_BITS{1'b0}};
                    busy_d     = 1'b1;
                    lut_addr_d = x_vec[FRAC_W +: ADDR_W];
                end else begin
                    busy_d     = 1'b0;
                end
            end
            FETCH: begin
                base_d  = lut_base;
                next_d  = lut_next;
                frac_d  = x_q[int'(idx_q)*IN_W +: FRAC_W];
                state_d = CALC;
            end
            CALC: begin
                y_d[int'(idx_q)*DATA_W +: DATA_W] = interp_y_s;
                if (idx_q == IDX_BITS'(LAST)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d      = idx_nxt_s;
                    state_d    = FETCH;
                    lut_addr_d = x_q[int'(idx_nxt_s)*IN_W + FRAC_W +: ADDR_W];
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= {IDX_BITS{1'b0}};
            x_q        <= {(N_NEURONS*IN_W){1'b0}};
            base_q     <= {DATA_W{1'b0}};
            next_q     <= {DATA_W{1'b0}};
            frac_q     <= {FRAC_W{1'b0}};
            lut_addr_q <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            y_q        <= {(N_NEURONS*DATA_W){1'b0}};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            base_q     <= base_d;
            next_q     <= next_d;
            frac_q     <= frac_d;
            lut_addr_q <= lut_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            y_q        <= y_d;
        end
    end

    assign lut_addr = lut_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign y_vec    = y_q;

endmodule

// File: tb/tb_act_lut_sequencer.sv
// Self-checking bench for act_lut_sequencer: directed scenarios plus randomized vectors
// against an integer floor-interpolation reference model and a behavioural LUT.
module tb_act_lut_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x_vec;
    logic [3:0]  lut_addr;
    logic [7:0]  lut_base;
    logic [7:0]  lut_next;
    logic        busy;
    logic        done;
    logic [31:0] y_vec;

    logic signed [7:0] lut [16];
    int checks;
    int errors;

    act_lut_sequencer #(
        .N_NEURONS (4),
        .IN_W      (8),
        .ADDR_W    (4),
        .FRAC_W    (4),
        .DATA_W    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_vec    (x_vec),
        .lut_addr (lut_addr),
        .lut_base (lut_base),
        .lut_next (lut_next),
        .busy     (busy),
        .done     (done),
        .y_vec    (y_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural LUT: entry 7 is its own successor, entry 15 wraps to entry 0.
    assign lut_base = lut[lut_addr];
    assign lut_next = (lut_addr == 4'd7) ? lut[7] : lut[lut_addr + 4'd1];

    function automatic int lut_val(input int a);
        return int'(lut[a]);
    endfunction

    function automatic logic [7:0] ref_elem(input logic [7:0] x);
        int a, f, b, n, d, q;
        a = int'(x) / 16;
        f = int'(x) % 16;
        b = lut_val(a);
        n = (a == 7) ? lut_val(7) : lut_val((a + 1) % 16);
        d = (n - b) * f;
        q = d / 16;
        if (d < 0 && (d % 16) != 0) q = q - 1;
        return 8'(b + q);
    endfunction

    function automatic logic [31:0] ref_vec(input logic [31:0] x);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = ref_elem(x[i*8 +: 8]);
        return r;
    endfunction

    // Starts a run from an idle cycle, returns the result and edges from accept to done.
    task automatic run_vec(input logic [31:0] xv, output logic [31:0] yv, output int lat);
        start = 1'b1;
        x_vec = xv;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        yv = y_vec;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; x_vec = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y_vec !== 32'd0 || lut_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b y=%h addr=%h, required 0/0/0/0", busy, done, y_vec, lut_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vector();
        logic [31:0] y;
        int lat;
        run_vec(32'hF87F1808, y, lat);
        checks++;
        if (y !== 32'hFA0F0D06) begin
            errors++;
            $display("FAIL vector_y: got %h, required %h", y, 32'hFA0F0D06);
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL vector_latency: got %0d, required 8", lat);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL vector_after_done: done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] y;
        int lat;
        run_vec(32'hFF807000, y, lat);
        checks++;
        if (y !== 32'hFFF10F00) begin
            errors++;
            $display("FAIL boundary_y: got %h, required %h", y, 32'hFFF10F00);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] xa, xb;
        int dones;
        xa = 32'h08183040;
        xb = 32'hC0D0E0F0;
        start = 1'b1;
        x_vec = xa;
        @(posedge clk); #1;
        x_vec = xb;
        dones = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
            if (c == 8) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_done_cycle: done=%b busy=%b, required 1/1", done, busy);
                end
            end
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d, required 1", dones);
        end
        checks++;
        if (busy !== 1'b0 || y_vec !== ref_vec(xa)) begin
            errors++;
            $display("FAIL busy_ignored_start: busy=%b y=%h, required 0 y=%h", busy, y_vec, ref_vec(xa));
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_reaccept: busy=%b, required 1", busy);
        end
        dones = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 1 || y_vec !== ref_vec(xb)) begin
            errors++;
            $display("FAIL busy_second_run: dones=%0d y=%h, required 1 y=%h", dones, y_vec, ref_vec(xb));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] y;
        int lat, dones;
        start = 1'b1;
        x_vec = 32'h11223308;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y_vec !== 32'd0 || lut_addr !== 4'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b y=%h addr=%h, required 0/0/0/0", busy, done, y_vec, lut_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: activity cycles=%0d, required 0", dones);
        end
        run_vec(32'h9A5B3C7D, y, lat);
        checks++;
        if (y !== ref_vec(32'h9A5B3C7D) || lat !== 8) begin
            errors++;
            $display("FAIL midrun_fresh: y=%h lat=%0d, required y=%h lat=8", y, lat, ref_vec(32'h9A5B3C7D));
        end
    endtask

    task automatic test_input_hold();
        logic [31:0] xc;
        int lat;
        xc = 32'h4DE2176B;
        start = 1'b1;
        x_vec = xc;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            x_vec = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (y_vec !== ref_vec(xc) || lat !== 8) begin
            errors++;
            $display("FAIL input_hold: y=%h lat=%0d, required y=%h lat=8", y_vec, lat, ref_vec(xc));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] xr, y;
        int lat;
        for (int v = 0; v < 1000; v++) begin
            xr = $urandom;
            run_vec(xr, y, lat);
            checks++;
            if (y !== ref_vec(xr) || lat !== 8) begin
                errors++;
                $display("FAIL random[%0d]: x=%h y=%h lat=%0d, required y=%h lat=8", v, xr, y, lat, ref_vec(xr));
            end
        end
    endtask

    initial begin
        lut[0]  = 8'sd0;   lut[1]  = 8'sd12;  lut[2]  = 8'sd15;  lut[3]  = 8'sd15;
        lut[4]  = 8'sd15;  lut[5]  = 8'sd15;  lut[6]  = 8'sd15;  lut[7]  = 8'sd15;
        lut[8]  = -8'sd15; lut[9]  = -8'sd15; lut[10] = -8'sd15; lut[11] = -8'sd15;
        lut[12] = -8'sd15; lut[13] = -8'sd15; lut[14] = -8'sd15; lut[15] = -8'sd12;
        checks = 0;
        errors = 0;
        test_reset();
        test_vector();
        test_boundaries();
        test_busy_ignore();
        test_reset_mid_run();
        test_input_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
